gray_stream_decoder: RTL and testbench
======================================

Name: gray_stream_decoder

Overview:
- Receiving end of a Gray-coded position/count stream, such as an encoder disc or a cross-domain counter.
- Per accepted word: converts Gray to binary, checks that consecutive words differ by exactly one step (±1 modulo 2^WIDTH), reports the step direction, and counts step errors.
- Tracks lock with a small state machine so a corrupted word forces a resynchronisation instead of a cascade of errors.

Parameters:
- WIDTH, 4, code word width in bits (≥2).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- EN  input  1  block enable; when 0 all inputs are ignored and all registered outputs hold.
- clear  input  1  synchronous clear of err_cnt and lock state.
- in_valid  input  1  in_gray is valid this cycle.
- in_gray  input  WIDTH  Gray-coded input word.
- out_valid  output  1  one-cycle pulse; out_bin, dir_up and step_err are valid.
- out_bin  output  WIDTH  decoded binary value of the last accepted word.
- dir_up  output  1  1 = last step was +1, 0 = last step was −1.
- step_err  output  1  last accepted word was an illegal step.
- err_cnt  output  ERR_CNT_W  saturating count of step errors.
- locked  output  1  1 while the state machine is in TRACK.

Behaviour:
Reset and registering:
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, out_bin=0, dir_up=1, step_err=0, err_cnt=0, locked=0, prev_bin=0.
- All outputs are registered.
- Latency: word sampled at edge N (EN=1, in_valid=1) appears on the outputs after edge N, with out_valid=1 for exactly one cycle.

Decode:
- out_bin[WIDTH-1] = g[WIDTH-1].
- out_bin[i] = out_bin[i+1] XOR g[i], for i from WIDTH-2 down to 0.
- Purely combinational ahead of the output register.
- diff = bin − prev_bin, computed modulo 2^WIDTH.

Enable and clear:
- EN=0: no state change, out_valid=0 next cycle, other outputs hold. EN has priority below rst_n only.
- clear=1 with EN=1: err_cnt←0, state←IDLE, locked←0, out_valid←0.
  - Any simultaneous in_valid word is dropped.
  - out_bin, dir_up and step_err hold.
  - clear has priority over in_valid.

States (transitions only on EN=1 and in_valid=1, clear=0):
- IDLE: accept word as reference, prev_bin←bin, out_bin←bin, step_err←0, dir_up unchanged → TRACK (locked=1 together with out_valid).
- TRACK:
  - diff=1: dir_up←1, step_err←0, stay.
  - diff=2^WIDTH−1: dir_up←0, step_err←0, stay.
  - diff=0 (repeated word): step_err←0, dir_up unchanged, stay; out_valid still pulses.
  - Any other diff: step_err←1, err_cnt←err_cnt+1 saturating at 2^ERR_CNT_W−1, dir_up unchanged → RESYNC (locked←0).
  - In every case prev_bin←bin and out_bin←bin.
- RESYNC: next word is taken as the new reference without a step check, step_err←0 → TRACK.

Boundaries:
- Wrap 2^WIDTH−1→0 is a legal +1 step; 0→2^WIDTH−1 is a legal −1 step.
- A stalled in_valid in any state is not an error.
- Reset mid-stream discards prev_bin; the first word after reset is a reference only.

Test Plan (WIDTH=4, ERR_CNT_W=8 unless stated):
1. Reset, EN=1; feed 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000 on consecutive cycles → out_bin = 0..15 then 0, each one cycle after its input; step_err always 0; dir_up=1 from the second word; locked=1 from the first out_valid; err_cnt=0.
2. Feed 0000 then 1000 then 1001 → out_bin 0,15,14; dir_up=0 after 1000; step_err=0.
3. Feed 0010,0110,1100,1101,1111 → out_bin 3,4,8,9,10:
   - At 8: step_err=1, err_cnt=1, locked=0.
   - At 9: step_err=0, locked=0 until this word accepted, then 1.
   - At 10: step_err=0, dir_up=1.
4. Feed 0011,0011 → two out_valid pulses, out_bin=2 both times; step_err=0; dir_up unchanged.
5. In TRACK, EN=0 with in_valid=1 for 3 cycles → out_valid=0, outputs hold. Then clear=1 together with in_valid → err_cnt=0, locked=0, no out_valid; next word is a reference.
6. ERR_CNT_W=2; alternate illegal jump and resync word 5 times → err_cnt saturates at 3. Then assert rst_n=0 mid-stream, asynchronously → all outputs return to reset values immediately.

Source files
------------

// File: rtl/gray_stream_if.sv
// Stream bundle between a Gray-code source and gray_stream_decoder.
// The source sets in_valid to mark a word; out_* reports the decoded result.
interface gray_stream_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  // Handshake: in_valid qualifies in_gray for one clock edge. There is no
  // backpressure. Every valid word seen while EN=1 and clear=0 is consumed.
  // out_valid is a one-cycle pulse that qualifies out_bin, dir_up and step_err.
  logic                 in_valid;
  logic [WIDTH-1:0]     in_gray;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_bin;
  logic                 dir_up;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 locked;

  modport master (
    output in_valid, in_gray,
    input  out_valid, out_bin, dir_up, step_err, err_cnt, locked
  );

  modport slave (
    input  in_valid, in_gray,
    output out_valid, out_bin, dir_up, step_err, err_cnt, locked
  );
endinterface

// File: rtl/gray_stream_decoder.sv
// Gray-to-binary stream decoder with +/-1 step checking, direction report,
// saturating error counter and a lock-tracking state machine.
module gray_stream_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       clear,
  gray_stream_if.slave s,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     STEP_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     STEP_DOWN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     STEP_NONE = {WIDTH{1'b0}};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 valid_q, valid_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 lock_q, lock_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]     dec;
  logic [WIDTH-1:0]     diff;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = s.in_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ s.in_gray[i];
    end
    diff = dec - prev_q;
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    if (EN) begin
      if (clear) begin
        cnt_d   = '0;
        state_d = IDLE;
        lock_d  = 1'b0;
      end else if (s.in_valid) begin
        valid_d = 1'b1;
        prev_d  = dec;
        bin_d   = dec;
        case (state_q)
          TRACK: begin
            if (diff == STEP_UP) begin
              dir_d = 1'b1;
              err_d = 1'b0;
            end else if (diff == STEP_DOWN) begin
              dir_d = 1'b0;
              err_d = 1'b0;
            end else if (diff == STEP_NONE) begin
              err_d = 1'b0;
            end else begin
              err_d   = 1'b1;
              cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
              state_d = RESYNC;
              lock_d  = 1'b0;
            end
          end
          // IDLE and RESYNC both adopt the word as a fresh reference.
          default: begin
            err_d   = 1'b0;
            state_d = TRACK;
            lock_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s.out_valid = valid_q;
  assign s.out_bin   = bin_q;
  assign s.dir_up    = dir_q;
  assign s.step_err  = err_q;
  assign s.err_cnt   = cnt_q;
  assign s.locked    = lock_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: two instances (8-bit and 2-bit error counter)
// share one stimulus stream and are compared against a behavioural model.
module tb_gray_stream_decoder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_r = 1'b0;
  logic clr_r = 1'b0;
  logic v_r = 1'b0;
  logic [W-1:0] g_r = '0;
  logic [1:0] dbg8, dbg2;

  int n_checks = 0;
  int n_fail = 0;

  gray_stream_if #(.WIDTH(W), .ERR_CNT_W(8)) sif8 ();
  gray_stream_if #(.WIDTH(W), .ERR_CNT_W(2)) sif2 ();

  assign sif8.in_valid = v_r;
  assign sif8.in_gray  = g_r;
  assign sif2.in_valid = v_r;
  assign sif2.in_gray  = g_r;

  gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .EN(en_r), .clear(clr_r),
    .s(sif8.slave), .dbg_state(dbg8)
  );

  gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .EN(en_r), .clear(clr_r),
    .s(sif2.slave), .dbg_state(dbg2)
  );

  // clock
  always #5 clk = ~clk;

  // reference model, one slot per instance
  int m_max[2] = '{255, 3};
  int m_bin[2], m_prev[2], m_cnt[2];
  bit m_valid[2], m_dir[2], m_err[2], m_need_ref[2];

  function automatic int gray2bin(input int g);
    int b = 0;
    for (int sh = 0; sh < W; sh++) b = b ^ (g >> sh);
    return b % M;
  endfunction

  function automatic int bin2gray(input int b);
    return (b ^ (b >> 1)) % M;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bin[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
      m_valid[k] = 0; m_dir[k] = 1; m_err[k] = 0; m_need_ref[k] = 1;
    end
  endtask

  task automatic model_step(input bit en, input bit clr, input bit v, input int g);
    int b, d;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0;
      if (en && clr) begin
        m_cnt[k] = 0;
        m_need_ref[k] = 1;
      end else if (en && v) begin
        b = gray2bin(g);
        m_valid[k] = 1;
        if (m_need_ref[k]) begin
          m_err[k] = 0;
          m_need_ref[k] = 0;
        end else begin
          d = (b - m_prev[k] + M) % M;
          if (d == 1) begin
            m_dir[k] = 1; m_err[k] = 0;
          end else if (d == M - 1) begin
            m_dir[k] = 0; m_err[k] = 0;
          end else if (d == 0) begin
            m_err[k] = 0;
          end else begin
            m_err[k] = 1;
            m_cnt[k] = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_cnt[k];
            m_need_ref[k] = 1;
          end
        end
        m_prev[k] = b;
        m_bin[k] = b;
      end
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input int k, input logic ov,
                            input logic [W-1:0] ob, input logic du, input logic se,
                            input int ec, input logic lk);
    check({nm, ".out_valid"}, int'(ov), int'(m_valid[k]));
    check({nm, ".out_bin"},   int'(ob), m_bin[k]);
    check({nm, ".dir_up"},    int'(du), int'(m_dir[k]));
    check({nm, ".step_err"},  int'(se), int'(m_err[k]));
    check({nm, ".err_cnt"},   ec,       m_cnt[k]);
    check({nm, ".locked"},    int'(lk), int'(!m_need_ref[k]));
  endtask

  task automatic check_all();
    check_inst("c8", 0, sif8.out_valid, sif8.out_bin, sif8.dir_up, sif8.step_err,
               int'(sif8.err_cnt), sif8.locked);
    check_inst("c2", 1, sif2.out_valid, sif2.out_bin, sif2.dir_up, sif2.step_err,
               int'(sif2.err_cnt), sif2.locked);
  endtask

  // driver: inputs change at negedge, model advances on posedge, check at next negedge
  task automatic drive(input bit en, input bit clr, input bit v, input int g);
    en_r = en; clr_r = clr; v_r = v; g_r = W'(g);
    @(posedge clk);
    model_step(en, clr, v, g);
    @(negedge clk);
    check_all();
  endtask

  task automatic word(input int b);
    drive(1, 0, 1, bin2gray(b));
  endtask

  task automatic async_reset();
    v_r = 0; en_r = 1; clr_r = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int cur, nb, r;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // full count up with wrap back to 0
    for (int i = 0; i <= M; i++) word(i % M);

    // down steps across the wrap
    drive(1, 1, 0, 0);
    word(0); word(15); word(14);
    check("p2_dir", int'(sif8.dir_up), 0);

    // illegal jump 4 -> 8, then resync
    drive(1, 1, 0, 0);
    word(3); word(4); word(8);
    check("p3_err_cnt", int'(sif8.err_cnt), 1);
    check("p3_locked", int'(sif8.locked), 0);
    word(9); word(10);
    check("p3_locked_after", int'(sif8.locked), 1);

    // repeated word
    drive(1, 1, 0, 0);
    word(2); word(2);

    // EN low holds everything, then clear beats a valid word
    for (int i = 0; i < 3; i++) drive(0, 0, 1, $urandom_range(0, M - 1));
    drive(1, 1, 1, bin2gray(3));
    word(7); word(8);

    // saturation of the narrow counter
    drive(1, 1, 0, 0);
    cur = 0;
    word(cur);
    for (int i = 0; i < 5; i++) begin
      cur = (cur + 5) % M; word(cur);
      cur = (cur + 1) % M; word(cur);
    end
    check("p6_sat2", int'(sif2.err_cnt), 3);
    check("p6_cnt8", int'(sif8.err_cnt), 5);
    async_reset();

    // randomized stream
    cur = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 3)      nb = (cur + 1) % M;
        else if (r < 6) nb = (cur + M - 1) % M;
        else if (r < 7) nb = cur;
        else            nb = $urandom_range(0, M - 1);
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 3) != 0, bin2gray(nb));
        if (en_r && v_r) cur = nb;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
